// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RISC-V M-extension multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up when entering DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int PW = 2 * DATA_W;
    localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] negate_w(input logic [DATA_W-1:0] v);
        return ~v + DATA_W'(1);
    endfunction

    function automatic logic [PW-1:0] negate_p(input logic [PW-1:0] v);
        return ~v + PW'(1);
    endfunction

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        return (is_signed && v[DATA_W-1]) ? negate_w(v) : v;
    endfunction

    muldiv_state_e     state_r, state_next_s;
    muldiv_op_e        op_s, op_r;
    logic              a_signed_s, b_signed_s, neg_a_s, neg_b_s, res_neg_s, res_neg_r;
    logic              div_zero_s, ovf_s, special_s, last_step_s;
    logic [DATA_W-1:0] mag_a_s, mag_b_s, special_res_s;
    logic [DATA_W-1:0] opnd_r, acc_hi_r, acc_lo_r, result_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W:0]   mul_sum_s, div_shift_s, div_trial_s;
    logic [DATA_W-1:0] step_hi_s, step_lo_s, div_raw_s, div_fix_s, final_s;
    logic [PW-1:0]     prod_s, prod_fix_s;
    logic              busy_s, done_s, busy_r, done_r;

    // Decode the incoming request: signedness, magnitudes and short-cut cases.
    always_comb begin
        op_s       = muldiv_op_e'(funct3);
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op_s)
            OP_MULH:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            OP_MULHSU: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
            OP_DIV:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            OP_REM:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
            default:   begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
        endcase
        neg_a_s    = a_signed_s & operand_a[DATA_W-1];
        neg_b_s    = b_signed_s & operand_b[DATA_W-1];
        mag_a_s    = magnitude(operand_a, a_signed_s);
        mag_b_s    = magnitude(operand_b, b_signed_s);
        // Remainder follows the dividend; everything else follows the product sign.
        if (op_s == OP_REM) begin
            res_neg_s = neg_a_s;
        end else begin
            res_neg_s = neg_a_s ^ neg_b_s;
        end
        div_zero_s = funct3[2] && (operand_b == {DATA_W{1'b0}});
        ovf_s      = ((op_s == OP_DIV) || (op_s == OP_REM)) &&
                     (operand_a == MIN_NEG) && (operand_b == {DATA_W{1'b1}});
        special_s  = div_zero_s || ovf_s;
        if (div_zero_s) begin
            special_res_s = funct3[1] ? operand_a : {DATA_W{1'b1}};
        end else if (ovf_s) begin
            special_res_s = funct3[1] ? {DATA_W{1'b0}} : operand_a;
        end else begin
            special_res_s = {DATA_W{1'b0}};
        end
    end

    // One iteration of shift-add multiply or restoring divide on the shared accumulators.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} +
                      (acc_lo_r[0] ? {1'b0, opnd_r} : {(DATA_W+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[DATA_W-1]};
        div_trial_s = div_shift_s - {1'b0, opnd_r};
        step_hi_s   = acc_hi_r;
        step_lo_s   = acc_lo_r;
        case (state_r)
            ST_MUL: begin
                step_hi_s = mul_sum_s[DATA_W:1];
                step_lo_s = {mul_sum_s[0], acc_lo_r[DATA_W-1:1]};
            end
            ST_DIV: begin
                if (!div_trial_s[DATA_W]) begin
                    step_hi_s = div_trial_s[DATA_W-1:0];
                    step_lo_s = {acc_lo_r[DATA_W-2:0], 1'b1};
                end else begin
                    step_hi_s = div_shift_s[DATA_W-1:0];
                    step_lo_s = {acc_lo_r[DATA_W-2:0], 1'b0};
                end
            end
            default: begin
                step_hi_s = acc_hi_r;
                step_lo_s = acc_lo_r;
            end
        endcase
        last_step_s = (cnt_r == CNT_W'(DATA_W - 1));
    end

    // Sign-correct and select the final result from the last iteration's values.
    always_comb begin
        prod_s     = {step_hi_s, step_lo_s};
        prod_fix_s = res_neg_r ? negate_p(prod_s) : prod_s;
        if ((op_r == OP_REM) || (op_r == OP_REMU)) begin
            div_raw_s = step_hi_s;
        end else begin
            div_raw_s = step_lo_s;
        end
        div_fix_s = res_neg_r ? negate_w(div_raw_s) : div_raw_s;
        case (op_r)
            OP_MUL:    final_s = prod_fix_s[DATA_W-1:0];
            OP_MULH:   final_s = prod_fix_s[PW-1:DATA_W];
            OP_MULHSU: final_s = prod_fix_s[PW-1:DATA_W];
            OP_MULHU:  final_s = prod_fix_s[PW-1:DATA_W];
            default:   final_s = div_fix_s;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: flush dominates, start only honoured when not computing.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (start) begin
                    if (special_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = funct3[2] ? ST_DIV : ST_MUL;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (last_step_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the next state so they can be registered.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_next_s)
            ST_MUL:  busy_s = 1'b1;
            ST_DIV:  busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Datapath: latch request, iterate, and capture the result on entering DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_r      <= OP_MUL;
            res_neg_r <= 1'b0;
            opnd_r    <= {DATA_W{1'b0}};
            acc_hi_r  <= {DATA_W{1'b0}};
            acc_lo_r  <= {DATA_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            result_r  <= {DATA_W{1'b0}};
        end else if (!flush) begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_r      <= op_s;
                        res_neg_r <= res_neg_s;
                        opnd_r    <= funct3[2] ? mag_b_s : mag_a_s;
                        acc_hi_r  <= {DATA_W{1'b0}};
                        acc_lo_r  <= funct3[2] ? mag_a_s : mag_b_s;
                        cnt_r     <= {CNT_W{1'b0}};
                        if (special_s) begin
                            result_r <= special_res_s;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_hi_r <= step_hi_s;
                    acc_lo_r <= step_lo_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_step_s) begin
                        result_r <= final_s;
                    end
                end
                default: cnt_r <= {CNT_W{1'b0}};
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed self-checking bench for muldiv_unit against an arithmetic reference.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a, operand_b;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_result;

    muldiv_unit #(.DATA_W(32)) dut (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V M semantics computed with plain wide/signed arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        longint      sa, sb;
        int          ia, ib;
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b}; p = sa * sb; return p[63:32]; end
            3'd2: begin sa = {{32{a[31]}}, a}; sb = {32'b0, b}; p = sa * sb; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one operation, scramble inputs afterwards, optionally poke start at cycle 'poke'.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int poke);
        int          lat;
        int          busy_cnt;
        int          exp_lat;
        logic [31:0] exp;
        exp     = ref_result(f, a, b);
        exp_lat = ref_latency(f, a, b);
        @(negedge clock);
        start = 1'b1; funct3 = f; operand_a = a; operand_b = b;
        @(posedge clock); #1;
        start = 1'b0; funct3 = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
        lat = 1;
        busy_cnt = 0;
        if (exp_lat > 1) check_eq("result_hold", result, last_result);
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            start = (lat == poke);
            if (start) funct3 = 3'($urandom);
            @(posedge clock); #1;
            start = 1'b0;
            lat++;
        end
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        check_eq("result", result, exp);
        last_result = exp;
        @(posedge clock); #1;
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("result_stable", result, exp);
    endtask

    initial begin
        int          dcnt;
        logic [2:0]  f;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = 3'd0; operand_a = 32'd0; operand_b = 32'd0;
        last_result = 32'd0;
        #12;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_result", result, 32'd0);
        @(posedge clock); #2;
        reset = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 0);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd7, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // start pulsed mid-operation is ignored
        run_op(3'd4, 32'd1234567, 32'hFFFF_FFF5, 5);
        run_op(3'd0, 32'hDEAD_BEEF, 32'd12345, 20);

        // flush at cycle 10 of a MUL
        @(negedge clock);
        start = 1'b1; funct3 = 3'd0; operand_a = 32'd7; operand_b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clock); #1; end
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        check_eq("flush_busy", 32'(busy), 32'd0);
        dcnt = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) dcnt++;
        end
        check_eq("flush_no_done", 32'(dcnt), 32'd0);
        check_eq("flush_result", result, last_result);
        run_op(3'd5, 32'd9, 32'd3, 0);

        // flush beats a simultaneous start, including a zero-divisor short cut
        @(negedge clock);
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; operand_a = 32'd77; operand_b = 32'd0;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        check_eq("flush_start_done", 32'(done), 32'd0);
        check_eq("flush_start_busy", 32'(busy), 32'd0);
        check_eq("flush_start_result", result, last_result);

        // asynchronous reset mid-DIV
        @(negedge clock);
        start = 1'b1; funct3 = 3'd4; operand_a = 32'd1000; operand_b = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_result", result, 32'd0);
        last_result = 32'd0;
        @(posedge clock); #2;
        reset = 1'b0;
        run_op(3'd5, 32'd100, 32'd7, 0);

        // randomized operations with boundary operands mixed in
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op(f, a, b, ((i % 5) == 0) ? int'($urandom_range(1, 30)) : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the operand and result width (any even value >= 8).
REQ-002 SHALL have parameter CNT_W, default $clog2(DATA_W)+1, giving the iteration counter width.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request a new operation this cycle.
REQ-006 SHALL have port funct3, input, 3, selecting the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port operand_a, input, DATA_W, rs1 value (multiplicand/dividend).
REQ-008 SHALL have port operand_b, input, DATA_W, rs2 value (multiplier/divisor).
REQ-009 SHALL have port flush, input, 1, abort any operation in progress (branch flush).
REQ-010 SHALL have port busy, output, 1, operation in progress; the pipeline stalls on it.
REQ-011 SHALL have port done, output, 1, single-cycle pulse marking result valid.
REQ-012 SHALL have port result, output, DATA_W, result of the last completed operation.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE; busy=1 exactly in MUL and DIV.
REQ-014 SHALL accept start only in IDLE or DONE (back-to-back allowed); start in MUL/DIV SHALL be ignored with no state change.
REQ-015 SHALL latch funct3, operand magnitudes and result-sign flags on an accepted start; later input changes SHALL have no effect.
REQ-016 SHALL treat operands as signed per RISC-V M: MULH both signed, MULHSU a signed/b unsigned, MULHU/DIVU/REMU unsigned.
REQ-017 SHALL compute multiply by radix-2 shift-add over the unsigned magnitudes into a 2*DATA_W product, one bit per cycle, DATA_W cycles in MUL.
REQ-018 SHALL compute divide by restoring division over the magnitudes, one quotient bit per cycle, DATA_W cycles in DIV.
REQ-019 SHALL apply sign correction (two's-complement negate) on the transition into DONE; remainder takes the dividend sign.
REQ-020 SHALL select low DATA_W product bits for MUL, high DATA_W bits for MULH/MULHSU/MULHU.
REQ-021 SHALL, for divisor 0, go IDLE->DONE directly: DIV/DIVU result all-ones, REM/REMU result = operand_a.
REQ-022 SHALL, for DIV/REM with operand_a = most-negative and operand_b = -1, go IDLE->DONE directly: DIV result = operand_a, REM result 0.
REQ-023 SHALL assert done for exactly the one cycle spent in DONE; latency start-cycle to done-cycle = DATA_W+1 normally, 1 for REQ-021/022 cases.
REQ-024 SHALL hold result stable from DONE until the next DONE.
REQ-025 SHALL on flush go to IDLE next edge from any state, suppressing done and leaving result unchanged; flush SHALL win over a simultaneous start.

Reset
REQ-026 SHALL on reset immediately force state IDLE, counter 0, busy 0, done 0, result 0, all internal accumulators 0, regardless of clock.
REQ-027 SHALL accept start on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL place the funct3 operation enum (muldiv_op_e) and FSM state enum in a shared package, imported alongside the pipeline-register package.
REQ-029 SHALL be a single module; no sub-module is required, magnitude/negate logic SHALL be local functions.

Verification (DATA_W=32)
REQ-030 SHALL test MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, busy high 32 cycles, done at cycle 33 after start.
REQ-031 SHALL test MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-032 SHALL test DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14, REMU -> 2.
REQ-033 SHALL test DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, each with done at cycle 1 and busy never high.
REQ-034 SHALL test flush at cycle 10 of a MUL -> busy 0 next cycle, no done, result unchanged; a following DIVU 9/3 returns 3.
REQ-035 SHALL test start pulsed mid-operation (ignored, original result delivered) and async reset mid-DIV (outputs 0 immediately, clean restart).
